// File: rtl/cheby_bus_initiator.sv
// Single-outstanding bus initiator for the Cheby VME-style memory interface.
// Optional wait-cycle timeout path is built only when CHEBY_INIT_TIMEOUT_EN is defined.
module cheby_bus_initiator #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  Clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:2] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:2] VMEAddr,
    output logic [DATA_WIDTH-1:0] VMEWrData,
    output logic                  VMERdMem,
    output logic                  VMEWrMem,
    input  logic [DATA_WIDTH-1:0] VMERdData,
    input  logic                  VMERdDone,
    input  logic                  VMEWrDone
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("cheby_bus_initiator: TIMEOUT must lie in 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:2]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;
    logic                    done;

`ifdef CHEBY_INIT_TIMEOUT_EN
    localparam logic [16:0] TMO_LIM = 17'(TIMEOUT);

    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        tmo_hit;

    // Compare the post-increment count so exactly TIMEOUT cycles are spent in WAIT.
    assign tmo_hit = ({1'b0, cnt_q} + 17'd1) >= TMO_LIM;
`endif

    // Only the done of the direction in flight is observed.
    assign done = we_q ? VMEWrDone : VMERdDone;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
`ifdef CHEBY_INIT_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_STROBE;
                    we_d    = cmd_we;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    rd_d    = ~cmd_we;
                    wr_d    = cmd_we;
                end
            end
            S_STROBE: begin
                state_d = S_WAIT;
`ifdef CHEBY_INIT_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (done) begin
                    state_d = S_RESP;
                    rdata_d = we_q ? '0 : VMERdData;
`ifdef CHEBY_INIT_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (tmo_hit) begin
                    state_d = S_RESP;
                    rdata_d = '1;
                    err_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d   = cnt_q + 16'd1;
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

`ifdef CHEBY_INIT_TIMEOUT_EN
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = ready_q;
    assign busy_o    = busy_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign VMEAddr   = addr_q;
    assign VMEWrData = wdata_q;
    assign VMERdMem  = rd_q;
    assign VMEWrMem  = wr_q;

endmodule

// File: tb/tb_cheby_bus_initiator.sv
// Self-checking bench for cheby_bus_initiator against a pipelined register-bank model.
// Timeout-specific steps follow CHEBY_INIT_TIMEOUT_EN.
module tb_cheby_bus_initiator;

    localparam int unsigned AW     = 4;
    localparam int unsigned DW     = 32;
    localparam int unsigned TMO    = 8;
    localparam int unsigned BUDGET = 40;
`ifdef CHEBY_INIT_TIMEOUT_EN
    localparam int unsigned HANG   = 3;
`else
    localparam int unsigned HANG   = 1000;
`endif
    localparam logic [95:0] RST_VEC = 96'd1 << 71;
    localparam logic [31:0] MASK [4] = '{32'hFFFF_FFFF, 32'h0000_07FF, 32'hFFFF_FFFF, 32'h0000_FFFF};

    logic          Clk, rst_n;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:2] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, busy_o;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:2] VMEAddr;
    logic [DW-1:0] VMEWrData, VMERdData;
    logic          VMERdMem, VMEWrMem, VMERdDone, VMEWrDone;

    int n_assert = 0;
    int n_fail   = 0;

    cheby_bus_initiator #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TMO)
    ) dut (
        .Clk       (Clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy_o    (busy_o),
        .VMEAddr   (VMEAddr),
        .VMEWrData (VMEWrData),
        .VMERdMem  (VMERdMem),
        .VMEWrMem  (VMEWrMem),
        .VMERdData (VMERdData),
        .VMERdDone (VMERdDone),
        .VMEWrDone (VMEWrDone)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Bank with input and output pipelining: read done 1 cycle, write done 2 cycles after strobe.
    logic        slave_mute = 1'b0;
    logic        spur_rd = 1'b0, spur_wr = 1'b0;
    logic [31:0] spur_data = 32'hDEAD_BEEF;
    logic        rd_done_q = 1'b0, wr_pend_q = 1'b0, wr_done_q = 1'b0;
    logic [31:0] rd_data_q = '0;
    logic [31:0] bank [4] = '{default: '0};

    always @(posedge Clk) begin
        rd_done_q <= VMERdMem && !slave_mute;
        rd_data_q <= bank[VMEAddr];
        wr_pend_q <= VMEWrMem && !slave_mute;
        wr_done_q <= wr_pend_q;
        if (VMEWrMem && !slave_mute) bank[VMEAddr] <= VMEWrData & MASK[VMEAddr];
    end

    assign VMERdData = spur_rd ? spur_data : rd_data_q;
    assign VMERdDone = rd_done_q | spur_rd;
    assign VMEWrDone = wr_done_q | spur_wr;

    // Reference contents of the bank as seen through completed transactions.
    logic [31:0] ref_mem [4] = '{default: '0};

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] outs();
        return 96'({cmd_ready, busy_o, rsp_valid, rsp_err, VMERdMem, VMEWrMem,
                    VMEAddr, VMEWrData, rsp_rdata});
    endfunction

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge Clk);
        rst_n = 1'b1;
        @(negedge Clk);
    endtask

    // Issues one command at a negedge, measures latency from acceptance, checks and consumes the response.
    task automatic run_txn(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                           input bit mute, input int unsigned hold);
        logic [31:0] exp_data = '0;
        logic        exp_err  = 1'b0;
        int unsigned exp_lat  = 0;
        int unsigned lat = 0, nrd = 0, nwr = 0, strobe_at = 0;
        bit          stable_ok = 1'b1, hold_ok = 1'b1;
        logic [33:0] held;

        if (mute) begin
`ifdef CHEBY_INIT_TIMEOUT_EN
            exp_data = '1;
            exp_err  = 1'b1;
            exp_lat  = TMO + 2;
`endif
        end else if (we) begin
            ref_mem[addr] = wdata & MASK[addr];
            exp_lat = 4;
        end else begin
            exp_data = ref_mem[addr];
            exp_lat  = 3;
        end

        slave_mute = mute;
        check("cmd_ready_idle", 96'(cmd_ready), 96'(1));
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(posedge Clk);
        #1 cmd_valid = 1'b0;

        for (int unsigned c = 1; c <= BUDGET; c++) begin
            @(negedge Clk);
            if (VMERdMem === 1'b1) nrd++;
            if (VMEWrMem === 1'b1) nwr++;
            if ((VMERdMem === 1'b1 || VMEWrMem === 1'b1) && strobe_at == 0) strobe_at = c;
            if (VMEAddr !== addr || VMEWrData !== wdata) stable_ok = 1'b0;
            if (rsp_valid === 1'b1) begin
                lat = c;
                break;
            end
        end

        check("rsp_latency", 96'(lat), 96'(exp_lat));
        if (lat == 0) begin
            slave_mute = 1'b0;
            pulse_reset();
            return;
        end
        check("strobe_count", 96'({nrd, nwr}), 96'({32'(!we), 32'(we)}));
        check("strobe_cycle", 96'(strobe_at), 96'(1));
        check("bus_stable", 96'(stable_ok), 96'(1));
        check("rsp_rdata", 96'(rsp_rdata), 96'(exp_data));
        check("rsp_err", 96'(rsp_err), 96'(exp_err));
        check("cmd_ready_resp", 96'({cmd_ready, busy_o}), 96'(2'b01));

        held = {rsp_valid, rsp_err, rsp_rdata};
        for (int unsigned h = 0; h < hold; h++) begin
            @(negedge Clk);
            if ({rsp_valid, rsp_err, rsp_rdata} !== held || cmd_ready !== 1'b0) hold_ok = 1'b0;
        end
        if (hold > 0) check("resp_hold", 96'(hold_ok), 96'(1));

        rsp_ready = 1'b1;
        @(posedge Clk);
        #1 rsp_ready = 1'b0;
        @(negedge Clk);
        check("after_handshake", 96'({cmd_ready, rsp_valid, busy_o}), 96'(3'b100));
        slave_mute = 1'b0;
    endtask

    task automatic spurious_done();
        int unsigned quiet = 0;
        spur_rd = 1'b1;
        spur_wr = 1'b1;
        @(negedge Clk);
        spur_rd = 1'b0;
        spur_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid === 1'b0 && busy_o === 1'b0 && cmd_ready === 1'b1) quiet++;
            @(negedge Clk);
        end
        check("spurious_ignored", 96'(quiet), 96'(3));
    endtask

    initial begin
        int unsigned busy_cnt;
        int unsigned stray;

        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        #3 rst_n  = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset_values", outs(), RST_VEC);
        rst_n = 1'b1;
        @(negedge Clk);
        check("post_reset_idle", outs(), RST_VEC);

        run_txn(1'b1, 2'd0, 32'h1234_5678, 1'b0, 0);
        run_txn(1'b0, 2'd0, 32'h0000_0000, 1'b0, 0);
        run_txn(1'b1, 2'd1, 32'hFFFF_FFFF, 1'b0, 0);
        run_txn(1'b0, 2'd1, 32'h0000_0000, 1'b0, 0);
        run_txn(1'b0, 2'd0, 32'h0000_0000, 1'b0, 5);

`ifdef CHEBY_INIT_TIMEOUT_EN
        run_txn(1'b0, 2'd2, 32'h0000_0000, 1'b1, 0);
        repeat (2) @(negedge Clk);
`endif
        spurious_done();
        run_txn(1'b0, 2'd0, 32'h0000_0000, 1'b0, 0);

        // Unanswered read, then reset while it waits.
        slave_mute = 1'b1;
        cmd_valid  = 1'b1;
        cmd_we     = 1'b0;
        cmd_addr   = 2'd2;
        cmd_wdata  = 32'h0BAD_F00D;
        @(posedge Clk);
        #1 cmd_valid = 1'b0;
        busy_cnt = 0;
        for (int unsigned i = 0; i < HANG; i++) begin
            @(negedge Clk);
            if (busy_o === 1'b1 && rsp_valid === 1'b0) busy_cnt++;
        end
        check("busy_while_waiting", 96'(busy_cnt), 96'(HANG));
        rst_n = 1'b0;
        #1 check("reset_in_wait", outs(), RST_VEC);
        slave_mute = 1'b0;
        repeat (2) @(negedge Clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (rsp_valid !== 1'b0 || busy_o !== 1'b0) stray++;
        end
        check("no_rsp_after_reset", 96'(stray), 96'(0));
        run_txn(1'b0, 2'd1, 32'h0000_0000, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            logic        r_we;
            logic [1:0]  r_addr;
            logic [31:0] r_data;
            r_we   = 1'($urandom_range(0, 1));
            r_addr = 2'($urandom_range(0, 3));
            r_data = $urandom();
            run_txn(r_we, r_addr, r_data, 1'b0, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
